// File: rtl/router_fifo_if.sv
// Handshake and data bundle between the register stage, a router_fifo and its destination reader.
// The master drives writes, reads and flushes; the slave (the FIFO) returns its flags and read data.
interface router_fifo_if #(
    parameter int WIDTH = 8
);
    logic             soft_reset;
    logic             write_enb;
    logic             read_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] data_out;

    modport master (
        output soft_reset, write_enb, read_enb, lfd_state, data_in,
        input  full, empty, data_out
    );

    modport slave (
        input  soft_reset, write_enb, read_enb, lfd_state, data_in,
        output full, empty, data_out
    );
endinterface

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router: stores {header flag, byte} entries and tracks packet length.
// Define ROUTER_FIFO_TRISTATE_EN to make the idle value of data_out high-impedance instead of zero.
module router_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input logic        clock,
    input logic        resetn,
    router_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
`ifdef ROUTER_FIFO_TRISTATE_EN
    localparam logic [WIDTH-1:0] IDLE = {WIDTH{1'bz}};
`else
    localparam logic [WIDTH-1:0] IDLE = '0;
`endif
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [WIDTH:0] mem [DEPTH];
    logic [WIDTH:0] rd_entry;
    logic           lfd_d;
    logic [6:0]     pkt_count;
    logic [WIDTH-1:0] data_q;
    logic           full;
    logic           empty;
    logic           wr_ok;
    logic           rd_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_ok    = bus.write_enb && !full;
    assign rd_ok    = bus.read_enb && !empty;
    assign rd_entry = mem[rd_ptr[AW-1:0]];

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.data_out = data_q;

    // Storage has no reset; a flush only moves the pointers.
    always_ff @(posedge clock) begin
        if (wr_ok && !bus.soft_reset)
            mem[wr_ptr[AW-1:0]] <= {lfd_d, bus.data_in};
    end

    // lfd_state leads the register-stage byte by one clock, so it is delayed before tagging.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pkt_count <= '0;
            data_q    <= IDLE;
            lfd_d     <= 1'b0;
        end else begin
            lfd_d <= bus.lfd_state;
            if (bus.soft_reset) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                pkt_count <= '0;
                data_q    <= IDLE;
            end else begin
                if (wr_ok)
                    wr_ptr <= wr_ptr + PTR_ONE;
                if (rd_ok) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                    if (rd_entry[WIDTH]) begin
                        data_q    <= rd_entry[WIDTH-1:0];
                        pkt_count <= {1'b0, rd_entry[7:2]} + 7'd1;
                    end else if (pkt_count != 7'd0) begin
                        data_q    <= rd_entry[WIDTH-1:0];
                        pkt_count <= pkt_count - 7'd1;
                    end else begin
                        // Payload with no open packet is a framing error: drop it.
                        data_q <= IDLE;
                    end
                end else if (pkt_count == 7'd0) begin
                    data_q <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_router_fifo.sv
// Directed scoreboard bench for router_fifo: a queue model of entries plus a packet-length model
// predicts full, empty and data_out after every clock.
module tb_router_fifo;
    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
`ifdef ROUTER_FIFO_TRISTATE_EN
    localparam logic [WIDTH-1:0] IDLE = {WIDTH{1'bz}};
`else
    localparam logic [WIDTH-1:0] IDLE = '0;
`endif

    logic clock;
    logic resetn;
    router_fifo_if #(.WIDTH(WIDTH)) bus ();

    router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [WIDTH:0]   sb_q [$];
    int               m_pkt;
    logic [WIDTH-1:0] m_dout;
    logic             m_lfd_d;

    task automatic check_output(input string tag);
        logic             exp_full;
        logic             exp_empty;
        exp_full  = (sb_q.size() == DEPTH);
        exp_empty = (sb_q.size() == 0);
        tests_run++;
        assert (bus.full === exp_full) else begin
            tests_failed++;
            $error("[TB] FAIL %s full: observed %b expected %b", tag, bus.full, exp_full);
        end
        tests_run++;
        assert (bus.empty === exp_empty) else begin
            tests_failed++;
            $error("[TB] FAIL %s empty: observed %b expected %b", tag, bus.empty, exp_empty);
        end
        tests_run++;
        assert (bus.data_out === m_dout) else begin
            tests_failed++;
            $error("[TB] FAIL %s data_out: observed %h expected %h", tag, bus.data_out, m_dout);
        end
    endtask

    // One clock of stimulus; the model advances on the same edge as the DUT.
    task automatic apply_stimulus(input logic we, input logic re, input logic lfd, input logic sr,
                                  input logic [WIDTH-1:0] din, input string tag);
        logic           wr_ok;
        logic           rd_ok;
        logic [WIDTH:0] e;
        bus.write_enb  = we;
        bus.read_enb   = re;
        bus.lfd_state  = lfd;
        bus.soft_reset = sr;
        bus.data_in    = din;
        wr_ok = we && (sb_q.size() < DEPTH);
        rd_ok = re && (sb_q.size() != 0);
        @(posedge clock);
        if (sr) begin
            sb_q.delete();
            m_pkt  = 0;
            m_dout = IDLE;
        end else begin
            if (rd_ok) begin
                e = sb_q.pop_front();
                if (e[WIDTH]) begin
                    m_dout = e[WIDTH-1:0];
                    m_pkt  = int'(e[7:2]) + 1;
                end else if (m_pkt != 0) begin
                    m_dout = e[WIDTH-1:0];
                    m_pkt--;
                end else begin
                    m_dout = IDLE;
                end
            end else if (m_pkt == 0) begin
                m_dout = IDLE;
            end
            if (wr_ok)
                sb_q.push_back({m_lfd_d, din});
        end
        m_lfd_d = lfd;
        #1 check_output(tag);
    endtask

    task automatic write_header(input logic [WIDTH-1:0] hdr);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, "hdr_lfd");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, hdr, "hdr_write");
    endtask

    task automatic write_byte(input logic [WIDTH-1:0] b, input string tag);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, b, tag);
    endtask

    task automatic read_byte(input string tag);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, tag);
    endtask

    task automatic idle_cycle(input string tag);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, tag);
    endtask

    initial begin
        resetn         = 1'b0;
        bus.soft_reset = 1'b0;
        bus.write_enb  = 1'b0;
        bus.read_enb   = 1'b0;
        bus.lfd_state  = 1'b0;
        bus.data_in    = '0;
        m_pkt   = 0;
        m_dout  = IDLE;
        m_lfd_d = 1'b0;
        #2 check_output("reset");
        #10 resetn = 1'b1;

        // Basic packet: header 0D (3 payload bytes), A1..A3, parity.
        write_header(8'h0D);
        write_byte(8'hA1, "pkt1_wr");
        write_byte(8'hA2, "pkt1_wr");
        write_byte(8'hA3, "pkt1_wr");
        write_byte(8'h5C, "pkt1_parity_wr");
        for (int i = 0; i < 5; i++) read_byte("pkt1_rd");
        idle_cycle("pkt1_idle");

        // Fill to full with a long header so every byte stays visible.
        write_header(8'hFC);
        for (int i = 0; i < DEPTH - 1; i++) write_byte(8'($urandom_range(0, 255)), "fill_wr");
        write_byte(8'hEE, "drop_when_full");
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'hDD, "full_read_write");
        for (int i = 0; i < DEPTH - 1; i++) read_byte("drain_rd");
        idle_cycle("drained");
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h55, "empty_read_write");
        read_byte("empty_rw_rd");
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, "flush");

        // Soft reset in the middle of a packet, then a fresh packet.
        write_header(8'h0D);
        write_byte(8'hA1, "pkt2_wr");
        write_byte(8'hA2, "pkt2_wr");
        write_byte(8'hA3, "pkt2_wr");
        write_byte(8'h11, "pkt2_parity_wr");
        read_byte("pkt2_rd");
        read_byte("pkt2_rd");
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h99, "soft_reset_mid");
        idle_cycle("after_soft_reset");
        write_header(8'h05);
        write_byte(8'hB1, "pkt3_wr");
        write_byte(8'h3C, "pkt3_parity_wr");
        for (int i = 0; i < 3; i++) read_byte("pkt3_rd");
        idle_cycle("pkt3_idle");

        // Zero-length packet: header then parity only.
        write_header(8'h01);
        write_byte(8'h01, "zero_len_parity_wr");
        read_byte("zero_len_rd");
        read_byte("zero_len_rd");
        read_byte("zero_len_idle");

        // Framing error: payload with no open packet is popped and discarded.
        write_byte(8'h42, "orphan_wr");
        read_byte("orphan_rd");

        // Asynchronous reset between edges while a write is pending.
        write_header(8'h0D);
        write_byte(8'hA1, "pkt4_wr");
        read_byte("pkt4_hdr_rd");
        bus.write_enb = 1'b1;
        bus.read_enb  = 1'b0;
        bus.data_in   = 8'h77;
        #2 resetn = 1'b0;
        sb_q.delete();
        m_pkt   = 0;
        m_dout  = IDLE;
        m_lfd_d = 1'b0;
        #1 check_output("async_reset");
        @(negedge clock);
        bus.write_enb = 1'b0;
        resetn = 1'b1;
        idle_cycle("post_reset_idle");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
